cordic_vectoring: RTL

//  Inverse of the rotation-mode cordic core: vectoring-mode CORDIC that converts a

---
 rtl/cordic_vectoring_pkg.sv | 49 ++++
 rtl/cordic_vectoring_if.sv | 27 ++
 rtl/cordic_vectoring_atan_rom.sv | 33 +++
 rtl/cordic_vectoring.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_vectoring_pkg.sv
// Shared definitions for the vectoring-mode CORDIC.
//  - FSM state encodings (plain logic constants so older tools can use them).
//  - atan_base(): arctangent table for micro-rotation i. Angles use a scale
//    of 2^19 counts per pi, which is D_WIDTH+GUARD at the defaults. Other
//    configurations rescale this table inside the ROM.
//  - k_gain(): CORDIC gain compensation 0.6072529350 * 2^(dw-1), rounded.
package cordic_vectoring_pkg;

  localparam int ATAN_SCALE_BITS = 19;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // round(atan(2^-i) * 2^19 / pi)
  function automatic int atan_base(input int i);
    case (i)
      0:  return 131072;
      1:  return 77376;
      2:  return 40884;
      3:  return 20753;
      4:  return 10417;
      5:  return 5213;
      6:  return 2607;
      7:  return 1304;
      8:  return 652;
      9:  return 326;
      10: return 163;
      11: return 81;
      12: return 41;
      13: return 20;
      14: return 10;
      15: return 5;
      16: return 3;
      17: return 1;
      18: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int k_gain(input int dw);
    return int'(0.6072529350 * (2.0 ** (dw - 1)));
  endfunction

endpackage

// File: rtl/cordic_vectoring_if.sv
// Handshake bundle for the vectoring CORDIC.
//  in_valid/in_ready/x_in/y_in : input sample handshake (master drives valid+data)
//  out_valid/out_ready         : result handshake (slave drives valid)
//  z_out                       : signed angle, pi = 2^D_WIDTH
//  mag_out                     : unsigned gain-compensated magnitude
interface cordic_vectoring_if #(
  parameter int D_WIDTH = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [D_WIDTH-1:0] x_in;
  logic signed [D_WIDTH-1:0] y_in;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [D_WIDTH+1:0] z_out;
  logic        [D_WIDTH-1:0] mag_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, z_out, mag_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, z_out, mag_out
  );
endinterface

// File: rtl/cordic_vectoring_atan_rom.sv
// Combinational arctangent lookup for micro-rotation index i_idx.
//  i_idx  : iteration index
//  o_atan : atan(2^-i) in internal angle units (pi = 2^(D_WIDTH+GUARD))
module cordic_vectoring_atan_rom
  import cordic_vectoring_pkg::*;
#(
  parameter int D_WIDTH = 16,
  parameter int GUARD   = 3,
  parameter int IDX_W   = 4,
  parameter int Z_W     = D_WIDTH + 2 + GUARD
) (
  input  logic        [IDX_W-1:0] i_idx,
  output logic signed [Z_W-1:0]   o_atan
);

  // Base table is at 2^19 per pi; shift to the configured angle scale.
  localparam int SH     = D_WIDTH + GUARD - ATAN_SCALE_BITS;
  localparam int SH_NEG = (SH < 0) ? -SH : 0;
  localparam int SH_POS = (SH > 0) ? SH : 0;
  localparam int SH_RND = (SH < 0) ? (-SH - 1) : 0;

  function automatic longint scaled(input int idx);
    longint b;
    b = longint'(atan_base(idx));
    if (SH >= 0) return b <<< SH_POS;
    return (b + (longint'(1) <<< SH_RND)) >>> SH_NEG;
  endfunction

  always_comb begin
    o_atan = Z_W'(scaled(int'(i_idx)));
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC: converts (x,y) to angle atan2(y,x) and magnitude.
// One micro-rotation per clock; single sample in flight.
//  clk   : clock, rising edge
//  rst_n : asynchronous active-low reset
//  bus   : slave side of cordic_vectoring_if
//          in_valid/in_ready/x_in/y_in   sample input
//          out_valid/out_ready           result handshake, result held until accepted
//          z_out   signed angle, LSB pi/2^D_WIDTH, range (-pi, +pi]
//          mag_out unsigned magnitude, LSB 2^-(D_WIDTH-1), saturating
module cordic_vectoring
  import cordic_vectoring_pkg::*;
#(
  parameter int D_WIDTH = 16,
  parameter int ITERS   = D_WIDTH - 1,
  parameter int GUARD   = 3
) (
  input logic              clk,
  input logic              rst_n,
  cordic_vectoring_if.slave bus
);

  localparam int W       = D_WIDTH + 2 + GUARD;   // internal x/y/z width
  localparam int Z_OUT_W = D_WIDTH + 2;
  localparam int IDX_W   = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int K_W     = D_WIDTH + 1;
  localparam int P_W     = W + K_W;
  localparam int MAG_SH  = D_WIDTH - 1 + GUARD;

  localparam logic signed [K_W-1:0] K_GAIN   = K_W'(k_gain(D_WIDTH));
  localparam logic signed [P_W-1:0] MAG_HALF = P_W'(1) <<< (MAG_SH - 1);
  localparam logic signed [P_W-1:0] MAG_MAX  = {{(P_W-D_WIDTH){1'b0}}, {D_WIDTH{1'b1}}};
  localparam logic signed [W-1:0]   Z_HALF   = W'(1) <<< (GUARD - 1);
  localparam logic signed [W-1:0]   Z_MAX    = W'(1) <<< D_WIDTH;
  localparam logic signed [W-1:0]   Z_MIN    = W'(1) - Z_MAX;
  localparam logic signed [W-1:0]   Z_QUAD   = W'(1) <<< (D_WIDTH - 1 + GUARD);

  // Round half-up, drop the guard/gain fraction, clamp to the unsigned range.
  function automatic logic [D_WIDTH-1:0] sat_mag(input logic signed [P_W-1:0] p);
    logic signed [P_W-1:0] r;
    r = (p + MAG_HALF) >>> MAG_SH;
    if (r < 0)       return '0;
    if (r > MAG_MAX) return '1;
    return r[D_WIDTH-1:0];
  endfunction

  // Round half-up out of the guard bits; keep the result inside (-pi, +pi].
  function automatic logic signed [Z_OUT_W-1:0] round_z(input logic signed [W-1:0] z);
    logic signed [W-1:0] r;
    r = (z + Z_HALF) >>> GUARD;
    if (r > Z_MAX) r = Z_MAX;
    if (r < Z_MIN) r = Z_MIN;
    return r[Z_OUT_W-1:0];
  endfunction

  state_t                     r_state;
  logic        [IDX_W-1:0]    r_iter;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic signed [Z_OUT_W-1:0]  r_z_out;
  logic        [D_WIDTH-1:0]  r_mag_out;

  logic signed [W-1:0]        r_x;
  logic signed [W-1:0]        r_y;
  logic signed [W-1:0]        r_z;
  logic                       r_zero;

  logic signed [W-1:0]        w_x_sh;
  logic signed [W-1:0]        w_y_sh;
  logic signed [W-1:0]        w_atan;
  logic signed [P_W-1:0]      w_prod;
  logic                       w_last;
  logic signed [W-1:0]        w_x_ext;
  logic signed [W-1:0]        w_y_ext;

  assign w_x_ext = {{2{bus.x_in[D_WIDTH-1]}}, bus.x_in, {GUARD{1'b0}}};
  assign w_y_ext = {{2{bus.y_in[D_WIDTH-1]}}, bus.y_in, {GUARD{1'b0}}};
  assign w_x_sh  = r_x >>> r_iter;
  assign w_y_sh  = r_y >>> r_iter;
  assign w_prod  = P_W'(r_x) * P_W'(K_GAIN);
  assign w_last  = (r_iter == IDX_W'(ITERS - 1));

  cordic_vectoring_atan_rom #(
    .D_WIDTH (D_WIDTH),
    .GUARD   (GUARD),
    .IDX_W   (IDX_W),
    .Z_W     (W)
  ) u_atan_rom (
    .i_idx  (r_iter),
    .o_atan (w_atan)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.z_out     = r_z_out;
  assign bus.mag_out   = r_mag_out;

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_iter      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_z_out     <= '0;
      r_mag_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_state    <= S_PRE;
            r_in_ready <= 1'b0;
          end
        end
        S_PRE: begin
          r_state <= S_ITER;
          r_iter  <= '0;
        end
        S_ITER: begin
          if (w_last) r_state <= S_SCALE;
          else        r_iter  <= r_iter + 1'b1;
        end
        S_SCALE: begin
          // (0,0) would otherwise accumulate every table angle on the d=-1 path.
          r_z_out     <= r_zero ? '0 : round_z(r_z);
          r_mag_out   <= sat_mag(w_prod);
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          r_x    <= w_x_ext;
          r_y    <= w_y_ext;
          r_z    <= '0;
          r_zero <= (bus.x_in == '0) && (bus.y_in == '0);
        end
      end
      S_PRE: begin
        // Fold left half-plane into the right so iterations only cover +-pi/2.
        // y==0 with x<0 takes the +pi/2 branch, giving +pi rather than -pi.
        if (r_x < 0) begin
          if (r_y >= 0) begin
            r_x <= r_y;
            r_y <= -r_x;
            r_z <= Z_QUAD;
          end else begin
            r_x <= -r_y;
            r_y <= r_x;
            r_z <= -Z_QUAD;
          end
        end
      end
      S_ITER: begin
        if (r_y < 0) begin
          r_x <= r_x - w_y_sh;
          r_y <= r_y + w_x_sh;
          r_z <= r_z - w_atan;
        end else begin
          r_x <= r_x + w_y_sh;
          r_y <= r_y - w_x_sh;
          r_z <= r_z + w_atan;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
